// File: rtl/jk_excitation_sequencer_if.sv
// Target/feedback/drive bundle between a controller and the JK excitation sequencer.
// slave = sequencer side, master = the side that supplies targets and Q feedback.
interface jk_excitation_sequencer_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 tgt_valid;
  logic [WIDTH-1:0]     tgt_data;
  logic                 tgt_ready;
  logic [WIDTH-1:0]     q_fb;
  logic [WIDTH-1:0]     j;
  logic [WIDTH-1:0]     k;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_cnt_clr;

  modport slave (
    input  tgt_valid, tgt_data, q_fb, err_cnt_clr,
    output tgt_ready, j, k, busy, done, err, err_cnt
  );

  modport master (
    output tgt_valid, tgt_data, q_fb, err_cnt_clr,
    input  tgt_ready, j, k, busy, done, err, err_cnt
  );
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Drives a JK flip-flop bank to a requested target for one clock, then checks the result.
// Optional macro JK_TOGGLE_EN: drive differing bits with j=k=1 instead of set/reset form.
module jk_excitation_sequencer #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  jk_excitation_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, APPLY, CHECK} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tgt_q, tgt_d;
  logic [WIDTH-1:0]     j_q, j_d;
  logic [WIDTH-1:0]     k_q, k_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     exc_j, exc_k;
  logic                 match;

  assign match = (bus.q_fb == tgt_q);

  // Per-bit excitation from current Q and latched target.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_TOGGLE_EN
      assign exc_j[gi] = bus.q_fb[gi] ^ tgt_q[gi];
      assign exc_k[gi] = bus.q_fb[gi] ^ tgt_q[gi];
`else
      assign exc_j[gi] = ~bus.q_fb[gi] &  tgt_q[gi];
      assign exc_k[gi] =  bus.q_fb[gi] & ~tgt_q[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    j_d       = j_q;
    k_d       = k_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_data;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        j_d     = exc_j;
        k_d     = exc_k;
        state_d = APPLY;
      end
      APPLY: begin
        // The bank samples j/k at the edge closing this cycle.
        j_d     = '0;
        k_d     = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (match) begin
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.err_cnt_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      tgt_q     <= tgt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Directed bench: sequencer driving a 4-bit JK bank model with an optional stuck-at-0 on bit 0.
module tb_jk_excitation_sequencer;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk;
  logic rst;
  logic fault;
  logic [W-1:0] bank_q;
  int n_vec;
  int n_bad;

  jk_excitation_sequencer_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus_if ();

  jk_excitation_sequencer #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK flip-flop bank: hold / reset / set / toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        case ({bus_if.j[b], bus_if.k[b]})
          2'b10:   bank_q[b] <= 1'b1;
          2'b01:   bank_q[b] <= 1'b0;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  assign bus_if.q_fb = fault ? {bank_q[W-1:1], 1'b0} : bank_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full target sequence starting from IDLE; inputs change 1 time unit after an edge.
  task automatic run_target(input logic [W-1:0] t, input logic chk_jk,
                            input logic [W-1:0] ej, input logic [W-1:0] ek,
                            input logic exp_ok, input logic clr_in_check);
    bus_if.tgt_valid = 1'b1;
    bus_if.tgt_data  = t;
    step();  // E0
    n_vec++;
    if (bus_if.busy !== 1'b1 || bus_if.tgt_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL accept: busy=%b ready=%b, required busy=1 ready=0", bus_if.busy, bus_if.tgt_ready);
    end
    bus_if.tgt_valid = 1'b0;
    bus_if.tgt_data  = ~t;
    step();  // E1: APPLY
    if (chk_jk) begin
      n_vec++;
      if (bus_if.j !== ej || bus_if.k !== ek) begin
        n_bad++;
        $display("FAIL apply_jk: j=%b k=%b, required j=%b k=%b", bus_if.j, bus_if.k, ej, ek);
      end
    end
    step();  // E2: CHECK
    n_vec++;
    if (bus_if.j !== '0 || bus_if.k !== '0) begin
      n_bad++;
      $display("FAIL jk_release: j=%b k=%b, required 0000/0000", bus_if.j, bus_if.k);
    end
    if (clr_in_check) bus_if.err_cnt_clr = 1'b1;
    step();  // E3
    bus_if.err_cnt_clr = 1'b0;
    n_vec++;
    if (bus_if.done !== exp_ok || bus_if.err !== !exp_ok) begin
      n_bad++;
      $display("FAIL result: done=%b err=%b, required done=%b err=%b", bus_if.done, bus_if.err, exp_ok, !exp_ok);
    end
    n_vec++;
    if (bus_if.tgt_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_return: ready=%b busy=%b, required 1/0", bus_if.tgt_ready, bus_if.busy);
    end
    step();
    n_vec++;
    if (bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_width: done=%b err=%b, required 0/0", bus_if.done, bus_if.err);
    end
    $display("target %b -> q_fb %b err_cnt %0d", t, bus_if.q_fb, bus_if.err_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus_if.j !== '0 || bus_if.k !== '0 || bus_if.tgt_ready !== 1'b1 || bus_if.busy !== 1'b0 ||
        bus_if.err_cnt !== '0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: j=%b k=%b ready=%b busy=%b cnt=%0d done=%b err=%b, required 0000 0000 1 0 0 0 0",
               bus_if.j, bus_if.k, bus_if.tgt_ready, bus_if.busy, bus_if.err_cnt, bus_if.done, bus_if.err);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_vec++;
    if (bus_if.tgt_ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: ready=%b done=%b err=%b, required 1 0 0", bus_if.tgt_ready, bus_if.done, bus_if.err);
    end
  endtask

  task automatic test_set_from_zero();
`ifdef JK_TOGGLE_EN
    run_target(4'b1010, 1'b1, 4'b1010, 4'b1010, 1'b1, 1'b0);
`else
    run_target(4'b1010, 1'b1, 4'b1010, 4'b0000, 1'b1, 1'b0);
`endif
    n_vec++;
    if (bus_if.q_fb !== 4'b1010) begin
      n_bad++;
      $display("FAIL set_q: q_fb=%b, required 1010", bus_if.q_fb);
    end
  endtask

  task automatic test_mixed();
`ifdef JK_TOGGLE_EN
    run_target(4'b0110, 1'b1, 4'b1100, 4'b1100, 1'b1, 1'b0);
`else
    run_target(4'b0110, 1'b1, 4'b0100, 4'b1000, 1'b1, 1'b0);
`endif
    n_vec++;
    if (bus_if.q_fb !== 4'b0110) begin
      n_bad++;
      $display("FAIL mixed_q: q_fb=%b, required 0110", bus_if.q_fb);
    end
  endtask

  task automatic test_fault();
    fault = 1'b1;
`ifdef JK_TOGGLE_EN
    run_target(4'b0001, 1'b1, 4'b0111, 4'b0111, 1'b0, 1'b0);
`else
    run_target(4'b0001, 1'b1, 4'b0001, 4'b0110, 1'b0, 1'b0);
`endif
    n_vec++;
    if (bus_if.err_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL err_cnt_one: err_cnt=%0d, required 1", bus_if.err_cnt);
    end
    for (int i = 1; i < 300; i++) begin
      run_target(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    n_vec++;
    if (bus_if.err_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL err_cnt_sat: err_cnt=%0d, required 255", bus_if.err_cnt);
    end
    bus_if.err_cnt_clr = 1'b1;
    step();
    bus_if.err_cnt_clr = 1'b0;
    n_vec++;
    if (bus_if.err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL err_cnt_clr: err_cnt=%0d, required 0", bus_if.err_cnt);
    end
    run_target(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    n_vec++;
    if (bus_if.err_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL err_cnt_after_clr: err_cnt=%0d, required 1", bus_if.err_cnt);
    end
    run_target(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    n_vec++;
    if (bus_if.err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_priority: err_cnt=%0d, required 0", bus_if.err_cnt);
    end
    fault = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Bank holds 0001 here; q_fb is now fault-free.
    bus_if.tgt_valid = 1'b1;
    bus_if.tgt_data  = 4'b1110;
    step();
    bus_if.tgt_valid = 1'b0;
    step();
    n_vec++;
`ifdef JK_TOGGLE_EN
    if (bus_if.j !== 4'b1111 || bus_if.k !== 4'b1111) begin
      n_bad++;
      $display("FAIL mid_apply: j=%b k=%b, required 1111/1111", bus_if.j, bus_if.k);
    end
`else
    if (bus_if.j !== 4'b1110 || bus_if.k !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_apply: j=%b k=%b, required 1110/0001", bus_if.j, bus_if.k);
    end
`endif
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus_if.j !== '0 || bus_if.k !== '0 || bus_if.busy !== 1'b0 || bus_if.tgt_ready !== 1'b1 ||
        bus_if.err_cnt !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: j=%b k=%b busy=%b ready=%b cnt=%0d, required 0000 0000 0 1 0",
               bus_if.j, bus_if.k, bus_if.busy, bus_if.tgt_ready, bus_if.err_cnt);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus_if.done !== 1'b0 || bus_if.err !== 1'b0 || bus_if.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_quiet: done=%b err=%b busy=%b, required 0 0 0", bus_if.done, bus_if.err, bus_if.busy);
      end
    end
`ifdef JK_TOGGLE_EN
    run_target(4'b0011, 1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0);
`else
    run_target(4'b0011, 1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq [16];
    seq = '{4'h5, 4'h9, 4'h2, 4'h7, 4'hA, 4'h1, 4'hF, 4'h3,
            4'h0, 4'hC, 4'h6, 4'hE, 4'hB, 4'h4, 4'h8, 4'hD};
    bus_if.tgt_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus_if.tgt_data = seq[c];
      n_vec++;
      if (bus_if.tgt_ready !== ((c % 4) == 0)) begin
        n_bad++;
        $display("FAIL b2b_ready c=%0d: ready=%b, required %b", c, bus_if.tgt_ready, ((c % 4) == 0));
      end
      step();
      n_vec++;
      if ((c % 4) == 3) begin
        if (bus_if.done !== 1'b1 || bus_if.q_fb !== seq[c-3]) begin
          n_bad++;
          $display("FAIL b2b_done c=%0d: done=%b q_fb=%b, required 1 %b", c, bus_if.done, bus_if.q_fb, seq[c-3]);
        end else begin
          $display("target %b -> q_fb %b (back-to-back)", seq[c-3], bus_if.q_fb);
        end
      end else if (bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle c=%0d: done=%b err=%b, required 0 0", c, bus_if.done, bus_if.err);
      end
    end
    bus_if.tgt_valid = 1'b0;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    fault = 1'b0;
    rst = 1'b0;
    bus_if.tgt_valid   = 1'b0;
    bus_if.tgt_data    = '0;
    bus_if.err_cnt_clr = 1'b0;
    #3;
    test_reset();
    test_set_from_zero();
    test_mixed();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
